retire_rat: RTL and testbench

- Retirement-side counterpart of the rename stage. Consumes in-order commits from the ROB and updates the architectural (retirement) register alias table.
- Returns superseded physical registers to the rename free list over the rrat_free/rrat_free_reg handshake.
- Publishes rrat_map, which the rename free list and FRAT use for flush recovery.
- Up to two commits are accepted per cycle. Only one free is returned per cycle, so a small return FIFO absorbs the rate mismatch.

---
 rtl/retire_rat_pkg.sv | 22 ++
 rtl/retire_rat_free_return_fifo.sv | 79 +++++++
 rtl/retire_rat.sv | 137 +++++++++++++
 tb/tb_retire_rat.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_rat_pkg.sv
// Shared types and constants for the retirement register alias table.
package retire_rat_pkg;

  localparam int unsigned NUM_ARCH = 32;
  localparam int unsigned PHYS_W   = 6;
  localparam int unsigned ARCH_W   = 5;

  typedef logic [PHYS_W-1:0] phys_tag_t;

  typedef struct packed {
    logic              valid;
    logic              regwr;
    logic [ARCH_W-1:0] arch;
    phys_tag_t         phys;
  } commit_slot_t;

  // Number of set bits in a two-slot strobe vector (0..2).
  function automatic logic [1:0] count2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/retire_rat_free_return_fifo.sv
// Two-in / one-out FIFO of physical tags awaiting return to the rename free list.
// Pushes are compacted so slot 0 lands ahead of slot 1; en_i low freezes everything.
module retire_rat_free_return_fifo
  import retire_rat_pkg::*;
#(
  parameter  int unsigned FREE_DEPTH = 8,
  localparam int unsigned PTR_W      = $clog2(FREE_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic [1:0]           push_i,
  input  phys_tag_t [1:0]      push_data_i,
  input  logic                 pop_i,
  output phys_tag_t            head_o,
  output logic [CNT_W-1:0]     count_o
);

  phys_tag_t        mem_q [FREE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_addr0_s, wr_addr1_s;
  logic [1:0]       push_n_s;
  logic             pop_s;

  // Pointer/count next state; a clear empties the FIFO, disable holds it.
  always_comb begin
    pop_s      = pop_i && (count_q != '0);
    push_n_s   = count2(push_i);
    wr_addr0_s = wr_ptr_q;
    wr_addr1_s = wr_ptr_q + PTR_W'(push_i[0]);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (!en_i) begin
      count_d = count_q;
    end else if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_n_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_q + CNT_W'(push_n_s) - CNT_W'(pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (en_i && !clr_i) begin
      if (push_i[0]) begin
        mem_q[wr_addr0_s] <= push_data_i[0];
      end
      if (push_i[1]) begin
        mem_q[wr_addr1_s] <= push_data_i[1];
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: applies in-order commits to the architectural map and
// returns superseded physical tags to rename, one per cycle, via a small FIFO.
module retire_rat #(
  parameter int unsigned NUM_ARCH     = retire_rat_pkg::NUM_ARCH,
  parameter int unsigned PHYS_W       = retire_rat_pkg::PHYS_W,
  parameter int unsigned FREE_DEPTH   = 8,
  parameter bit          ZERO_PROTECT = 1'b1
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             STALL,
  input  logic                             FLUSH,
  input  logic [1:0]                       commit_valid,
  input  logic [1:0]                       commit_regwr,
  input  logic [1:0][4:0]                  commit_arch,
  input  logic [1:0][PHYS_W-1:0]           commit_phys,
  output logic                             commit_ready,
  output logic                             rrat_free,
  output logic [PHYS_W-1:0]                rrat_free_reg,
  output logic [NUM_ARCH-1:0][PHYS_W-1:0]  rrat_map,
  output logic [31:0]                      retired_count
);

  localparam int unsigned CNT_W = $clog2(FREE_DEPTH) + 1;

  typedef retire_rat_pkg::commit_slot_t slot_t;

  slot_t [1:0]                      slot_s;
  logic [NUM_ARCH-1:0][PHYS_W-1:0]  map_q, map_d;
  logic                             free_q, free_d;
  logic [PHYS_W-1:0]                free_reg_q, free_reg_d;
  logic [31:0]                      retired_q, retired_d;
  logic [32:0]                      retired_sum_s;
  logic [1:0]                       accepted_s;
  logic [1:0]                       push_s;
  logic [1:0][PHYS_W-1:0]           push_data_s;
  logic [PHYS_W-1:0]                head_s;
  logic [CNT_W-1:0]                 fifo_count_s;

  // Two free slots of headroom guarantee a dual commit never overflows the FIFO.
  assign commit_ready = (fifo_count_s <= CNT_W'(FREE_DEPTH - 2)) && !STALL && !FLUSH;

  // Bundle each commit slot, qualified by acceptance.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot_s[s].valid = commit_valid[s] & commit_ready;
      slot_s[s].regwr = commit_regwr[s];
      slot_s[s].arch  = commit_arch[s];
      slot_s[s].phys  = commit_phys[s];
    end
  end

  // Map update and tag returns; slot 1 sees slot 0's write, so a same-arch
  // pair retires slot 0's phys as dead on arrival.
  always_comb begin
    map_d       = map_q;
    push_s      = 2'b00;
    push_data_s = '0;
    for (int s = 0; s < 2; s++) begin
      if (slot_s[s].valid && slot_s[s].regwr) begin
        push_s[s] = 1'b1;
        if (ZERO_PROTECT && (slot_s[s].arch == 5'd0)) begin
          push_data_s[s] = slot_s[s].phys;
        end else begin
          push_data_s[s]           = map_d[slot_s[s].arch];
          map_d[slot_s[s].arch]    = slot_s[s].phys;
        end
      end else begin
        push_s[s] = 1'b0;
      end
    end
  end

  // Saturating count of accepted commits.
  always_comb begin
    accepted_s    = {slot_s[1].valid, slot_s[0].valid};
    retired_sum_s = {1'b0, retired_q} + 33'(retire_rat_pkg::count2(accepted_s));
    if (retired_sum_s[32]) begin
      retired_d = 32'hFFFF_FFFF;
    end else begin
      retired_d = retired_sum_s[31:0];
    end
  end

  // Free-strobe output: pop the pre-edge head; flush drops pending returns.
  always_comb begin
    free_d     = free_q;
    free_reg_d = free_reg_q;
    if (STALL) begin
      free_d = free_q;
    end else if (FLUSH) begin
      free_d = 1'b0;
    end else if (fifo_count_s != '0) begin
      free_d     = 1'b1;
      free_reg_d = head_s;
    end else begin
      free_d = 1'b0;
    end
  end

  retire_rat_free_return_fifo #(
    .FREE_DEPTH (FREE_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .en_i        (!STALL),
    .clr_i       (FLUSH),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (1'b1),
    .head_o      (head_s),
    .count_o     (fifo_count_s)
  );

  // Architectural state and registered outputs; reset restores identity map.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        map_q[i] <= PHYS_W'(i);
      end
      free_q     <= 1'b0;
      free_reg_q <= '0;
      retired_q  <= 32'd0;
    end else begin
      map_q      <= map_d;
      free_q     <= free_d;
      free_reg_q <= free_reg_d;
      retired_q  <= retired_d;
    end
  end

  assign rrat_map      = map_q;
  assign rrat_free     = free_q;
  assign rrat_free_reg = free_reg_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_retire_rat;

  localparam int DEPTH = 8;
  localparam bit ZP    = 1'b1;

  logic             CLK = 1'b0;
  logic             RESET, STALL, FLUSH;
  logic [1:0]       commit_valid, commit_regwr;
  logic [1:0][4:0]  commit_arch;
  logic [1:0][5:0]  commit_phys;
  logic             commit_ready, rrat_free;
  logic [5:0]       rrat_free_reg;
  logic [31:0][5:0] rrat_map;
  logic [31:0]      retired_count;

  always #5 CLK = ~CLK;

  retire_rat #(.FREE_DEPTH(DEPTH), .ZERO_PROTECT(ZP)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .commit_valid(commit_valid), .commit_regwr(commit_regwr),
    .commit_arch(commit_arch), .commit_phys(commit_phys),
    .commit_ready(commit_ready), .rrat_free(rrat_free),
    .rrat_free_reg(rrat_free_reg), .rrat_map(rrat_map),
    .retired_count(retired_count)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: architectural map as an array, pending returns as a queue.
  int              m_map [32];
  int              m_q [$];
  bit              m_free;
  int              m_reg;
  longint unsigned m_ret;

  typedef struct packed {
    logic       st;
    logic [1:0] v;
    logic [1:0] w;
    logic [4:0] a0;
    logic [5:0] p0;
    logic [4:0] a1;
    logic [5:0] p1;
    logic       rdy;
    logic       fr;
    logic [5:0] frr;
    logic [4:0] ca;
    logic [5:0] cm;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_map[i] = i;
    m_q.delete();
    m_free = 1'b0;
    m_reg  = 0;
    m_ret  = 0;
  endtask

  function automatic bit model_ready();
    return (m_q.size() <= DEPTH - 2) && !STALL && !FLUSH;
  endfunction

  // Apply one clock edge of the rules to the model using the pre-edge state.
  task automatic model_edge(input bit rdy);
    int a;
    int p;
    if (STALL) return;
    if (FLUSH) begin
      m_q.delete();
      m_free = 1'b0;
      return;
    end
    if (m_q.size() > 0) begin
      m_free = 1'b1;
      m_reg  = m_q.pop_front();
    end else begin
      m_free = 1'b0;
    end
    if (!rdy) return;
    for (int s = 0; s < 2; s++) begin
      if (commit_valid[s]) begin
        if (m_ret < 64'hFFFF_FFFF) m_ret++;
        if (commit_regwr[s]) begin
          a = int'(commit_arch[s]);
          p = int'(commit_phys[s]);
          if (ZP && a == 0) m_q.push_back(p);
          else begin
            m_q.push_back(m_map[a]);
            m_map[a] = p;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] a0, input logic [5:0] p0,
                       input logic [4:0] a1, input logic [5:0] p1);
    STALL = st;
    FLUSH = fl;
    commit_valid = v;
    commit_regwr = w;
    commit_arch[0] = a0;
    commit_phys[0] = p0;
    commit_arch[1] = a1;
    commit_phys[1] = p1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 6'd0, 5'd0, 6'd0);
  endtask

  // One cycle: check ready, take the edge, then compare everything with the model.
  task automatic tick();
    bit rdy;
    int nbad;
    #1;
    rdy = model_ready();
    chk("commit_ready", 64'(commit_ready), 64'(rdy));
    @(posedge CLK);
    model_edge(rdy);
    #1;
    chk("rrat_free", 64'(rrat_free), 64'(m_free));
    chk("rrat_free_reg", 64'(rrat_free_reg), 64'(m_reg));
    chk("retired_count", 64'(retired_count), 64'(m_ret));
    nbad = 0;
    for (int i = 0; i < 32; i++) if (int'(rrat_map[i]) != m_map[i]) nbad++;
    chk("rrat_map_mismatches", 64'(nbad), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    idle();
    #1;
    model_reset();
    chk("reset_free", 64'(rrat_free), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    int got [$];
    int nbad;

    tbl[0]  = '{1'b0, 2'b01, 2'b01, 5'd5, 6'd40, 5'd0, 6'd0,  1'b1, 1'b0, 6'd0,  5'd5, 6'd40, 32'd1};
    tbl[1]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd5,  5'd5, 6'd40, 32'd1};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b0, 6'd5,  5'd5, 6'd40, 32'd1};
    tbl[3]  = '{1'b0, 2'b11, 2'b11, 5'd3, 6'd33, 5'd3, 6'd34, 1'b1, 1'b0, 6'd5,  5'd3, 6'd34, 32'd3};
    tbl[4]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd3,  5'd3, 6'd34, 32'd3};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd33, 5'd0, 6'd0,  32'd3};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b0, 6'd33, 5'd3, 6'd34, 32'd3};
    tbl[7]  = '{1'b0, 2'b01, 2'b01, 5'd0, 6'd50, 5'd0, 6'd0,  1'b1, 1'b0, 6'd33, 5'd0, 6'd0,  32'd4};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd50, 5'd0, 6'd0,  32'd4};
    tbl[9]  = '{1'b0, 2'b10, 2'b10, 5'd0, 6'd0,  5'd7, 6'd45, 1'b1, 1'b0, 6'd50, 5'd7, 6'd45, 32'd5};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd7,  5'd7, 6'd45, 32'd5};
    tbl[11] = '{1'b0, 2'b11, 2'b11, 5'd1, 6'd41, 5'd2, 6'd42, 1'b1, 1'b0, 6'd7,  5'd1, 6'd41, 32'd7};
    tbl[12] = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd1,  5'd2, 6'd42, 32'd7};
    tbl[13] = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b1, 6'd2,  5'd1, 6'd41, 32'd7};
    tbl[14] = '{1'b1, 2'b01, 2'b01, 5'd4, 6'd44, 5'd0, 6'd0,  1'b0, 1'b1, 6'd2,  5'd4, 6'd4,  32'd7};
    tbl[15] = '{1'b0, 2'b00, 2'b00, 5'd0, 6'd0,  5'd0, 6'd0,  1'b1, 1'b0, 6'd2,  5'd4, 6'd4,  32'd7};
    tbl[16] = '{1'b0, 2'b01, 2'b00, 5'd6, 6'd46, 5'd0, 6'd0,  1'b1, 1'b0, 6'd2,  5'd6, 6'd6,  32'd8};

    // Reset state.
    RESET = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_rrat_free", 64'(rrat_free), 64'd0);
    chk("reset_free_reg", 64'(rrat_free_reg), 64'd0);
    chk("reset_map7", 64'(rrat_map[7]), 64'd7);
    chk("reset_map31", 64'(rrat_map[31]), 64'd31);
    chk("reset_retired", 64'(retired_count), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("reset_ready", 64'(commit_ready), 64'd1);

    // Directed table.
    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].st, 1'b0, tbl[k].v, tbl[k].w, tbl[k].a0, tbl[k].p0, tbl[k].a1, tbl[k].p1);
      #1;
      chk($sformatf("tbl%0d_ready", k), 64'(commit_ready), 64'(tbl[k].rdy));
      tick();
      chk($sformatf("tbl%0d_free", k), 64'(rrat_free), 64'(tbl[k].fr));
      chk($sformatf("tbl%0d_free_reg", k), 64'(rrat_free_reg), 64'(tbl[k].frr));
      chk($sformatf("tbl%0d_map", k), 64'(rrat_map[tbl[k].ca]), 64'(tbl[k].cm));
      chk($sformatf("tbl%0d_retired", k), 64'(retired_count), 64'(tbl[k].ret));
    end

    // Back-to-back dual commits until the FIFO throttles, then drain in order.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 2'b11, 2'b11, 5'(8 + 2 * i), 6'(32 + 2 * i), 5'(9 + 2 * i), 6'(33 + 2 * i));
      tick();
      if (rrat_free) got.push_back(int'(rrat_free_reg));
    end
    drive(1'b0, 1'b0, 2'b11, 2'b11, 5'd30, 6'd60, 5'd31, 6'd61);
    #1;
    chk("full_ready_low", 64'(commit_ready), 64'd0);
    tick();
    if (rrat_free) got.push_back(int'(rrat_free_reg));
    idle();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rrat_free) got.push_back(int'(rrat_free_reg));
    end
    chk("b2b_free_count", 64'(got.size()), 64'd12);
    nbad = 0;
    for (int i = 0; i < got.size() && i < 12; i++) if (got[i] != 8 + i) nbad++;
    chk("b2b_order_mismatches", 64'(nbad), 64'd0);
    chk("b2b_map30", 64'(rrat_map[30]), 64'd30);

    // Flush with three pending returns.
    do_reset();
    drive(1'b0, 1'b0, 2'b11, 2'b11, 5'd10, 6'd50, 5'd11, 6'd51);
    tick();
    drive(1'b0, 1'b0, 2'b11, 2'b11, 5'd12, 6'd52, 5'd13, 6'd53);
    tick();
    drive(1'b0, 1'b1, 2'b11, 2'b11, 5'd14, 6'd54, 5'd15, 6'd55);
    tick();
    chk("flush_free", 64'(rrat_free), 64'd0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_flush_free", 64'(rrat_free), 64'd0);
    end
    chk("flush_map13", 64'(rrat_map[13]), 64'd53);
    chk("flush_map14", 64'(rrat_map[14]), 64'd14);
    chk("flush_ready", 64'(commit_ready), 64'd1);

    // Zero-protected commit: map[0] untouched, committed tag returned.
    drive(1'b0, 1'b0, 2'b01, 2'b01, 5'd0, 6'd50, 5'd0, 6'd0);
    tick();
    chk("zp_map0", 64'(rrat_map[0]), 64'd0);
    idle();
    tick();
    chk("zp_free", 64'(rrat_free), 64'd1);
    chk("zp_free_reg", 64'(rrat_free_reg), 64'd50);

    // Reset mid-operation with two entries pending and a strobe active.
    do_reset();
    drive(1'b0, 1'b0, 2'b11, 2'b11, 5'd20, 6'd40, 5'd21, 6'd41);
    tick();
    drive(1'b0, 1'b0, 2'b01, 2'b01, 5'd22, 6'd42, 5'd0, 6'd0);
    tick();
    RESET = 1'b0;
    idle();
    #1;
    model_reset();
    chk("midrst_free", 64'(rrat_free), 64'd0);
    chk("midrst_free_reg", 64'(rrat_free_reg), 64'd0);
    chk("midrst_map20", 64'(rrat_map[20]), 64'd20);
    chk("midrst_retired", 64'(retired_count), 64'd0);
    @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_reset_free", 64'(rrat_free), 64'd0);
    end

    // Randomized traffic with small arch range for frequent collisions.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
            5'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
      tick();
    end
    idle();
    repeat (10) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
